// File: rtl/axis_upsample2x_stream_pkg.sv
// Shared definitions for the 2x streaming upsampler.
//   - ups_mode_t  : output fill mode (nearest-neighbour / zero-insert)
//   - ups_state_t : job FSM state encoding, also exported on state_dbg
//   - UPS_MAX_LOG2_DIM : default largest input dimension exponent
package axis_upsample2x_stream_pkg;

    localparam int UPS_MAX_LOG2_DIM = 6;

    typedef enum logic {
        UPS_NEAREST = 1'b0,
        UPS_ZERO    = 1'b1
    } ups_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ups_state_t;

endpackage

// File: rtl/axis_upsample2x_stream_line_bank.sv
// One line buffer bank: 2^ADDR_WIDTH words, single write port, single
// combinational read port, plus a full flag marking a complete buffered row.
// Ports:
//   clk, reset      clock, synchronous active-low reset (clears full only)
//   wr_en/addr/data write port
//   set_full        row complete, bank becomes full
//   clr_full        row fully emitted, bank becomes free
//   rd_addr/rd_data read port
//   full            bank holds a complete row
module upsample_line_bank
    import axis_upsample2x_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = UPS_MAX_LOG2_DIM
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  set_full,
    input  logic                  clr_full,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Storage carries no reset; emptiness is tracked solely by the full flag.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            full <= 1'b0;
        end else if (set_full) begin
            full <= 1'b1;
        end else if (clr_full) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_upsample2x_stream.sv
// Streaming 2x spatial upsampler. Accepts C channels of an N x N map
// (N = 2^k) and emits C channels of 2N x 2N through two ping-pong line banks.
// Handshake: a beat transfers on a rising clk edge where tvalid && tready;
// the source holds tvalid/tdata/tlast stable until that transfer.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   cfg_start/log2_dim/channels/mode  job configuration, sampled in IDLE
//   busy, done, tlast_err      job status (done is a one-cycle pulse)
//   s_axis_*                   input pixel stream
//   m_axis_*                   output pixel stream (registered)
//   state_dbg                  current FSM state
module axis_upsample2x_stream
    import axis_upsample2x_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_LOG2_DIM = UPS_MAX_LOG2_DIM,
    parameter int CH_WIDTH     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [2:0]            cfg_log2_dim,
    input  logic [CH_WIDTH-1:0]   cfg_channels,
    input  logic                  cfg_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  tlast_err,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output ups_state_t            state_dbg
);

    localparam int             CW     = MAX_LOG2_DIM + 1;
    localparam logic [2:0]     MAX_K  = 3'(MAX_LOG2_DIM);
    localparam logic [CW-1:0]  CW_ONE = CW'(1);

    ups_state_t            state;
    logic [2:0]            k_q;
    logic [CH_WIDTH-1:0]   ch_q;
    ups_mode_t             mode_q;

    logic                  wbank, rbank, pass, m_last_job;
    logic [CW-1:0]         icol, irow, oc, orow;
    logic [CH_WIDTH-1:0]   ich, och;
    logic [CW-1:0]         n_m1, n2_m1;
    logic [1:0]            full, set_full, clr_full, wr_en;
    logic [DATA_WIDTH-1:0] rd_data [2];
    logic [DATA_WIDTH-1:0] rd_mux, out_word;
    logic                  in_hs, in_row_end, in_job_end;
    logic                  out_load, out_row_end, out_ch_last;

    assign state_dbg = state;

    // N-1 and 2N-1 from the latched exponent; 2N-1 is N-1 shifted with a 1 in.
    assign n_m1  = (CW_ONE << k_q) - CW_ONE;
    assign n2_m1 = {n_m1[CW-2:0], 1'b1};

    assign s_axis_tready = (state == ST_RUN) && !full[wbank];
    assign in_hs         = s_axis_tready && s_axis_tvalid;
    assign in_row_end    = in_hs && (icol == n_m1);
    assign in_job_end    = in_row_end && (irow == n_m1) && (ich == ch_q - CH_WIDTH'(1));

    assign out_load    = full[rbank] && (!m_axis_tvalid || m_axis_tready);
    assign out_row_end = out_load && pass && (oc == n2_m1);
    assign out_ch_last = out_row_end && (orow == n_m1);

    assign rd_mux   = rbank ? rd_data[1] : rd_data[0];
    // Zero-insert keeps only the even column of the first pass of each row.
    assign out_word = ((mode_q == UPS_NEAREST) || (!pass && !oc[0])) ? rd_mux : '0;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign wr_en[b]    = in_hs && (wbank == 1'(b));
        assign set_full[b] = in_row_end && (wbank == 1'(b));
        assign clr_full[b] = out_row_end && (rbank == 1'(b));

        upsample_line_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (MAX_LOG2_DIM)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (wr_en[b]),
            .wr_addr  (icol[MAX_LOG2_DIM-1:0]),
            .wr_data  (s_axis_tdata),
            .set_full (set_full[b]),
            .clr_full (clr_full[b]),
            .rd_addr  (oc[CW-1:1]),
            .rd_data  (rd_data[b]),
            .full     (full[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            k_q           <= '0;
            ch_q          <= '0;
            mode_q        <= UPS_NEAREST;
            busy          <= 1'b0;
            done          <= 1'b0;
            tlast_err     <= 1'b0;
            wbank         <= 1'b0;
            rbank         <= 1'b0;
            pass          <= 1'b0;
            icol          <= '0;
            irow          <= '0;
            ich           <= '0;
            oc            <= '0;
            orow          <= '0;
            och           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_last_job    <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        tlast_err <= 1'b0;
                        if (cfg_channels == '0 || cfg_log2_dim > MAX_K) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= ST_RUN;
                            busy   <= 1'b1;
                            k_q    <= cfg_log2_dim;
                            ch_q   <= cfg_channels;
                            mode_q <= ups_mode_t'(cfg_mode);
                            wbank  <= 1'b0;
                            rbank  <= 1'b0;
                            pass   <= 1'b0;
                            icol   <= '0;
                            irow   <= '0;
                            ich    <= '0;
                            oc     <= '0;
                            orow   <= '0;
                            och    <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (in_job_end) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (m_axis_tvalid && m_axis_tready && m_last_job) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Input side: tlast is only checked, it never alters counting.
            if (in_hs) begin
                if (s_axis_tlast != ((irow == n_m1) && (icol == n_m1))) tlast_err <= 1'b1;
                if (icol == n_m1) begin
                    icol  <= '0;
                    wbank <= ~wbank;
                    if (irow == n_m1) begin
                        irow <= '0;
                        ich  <= ich + CH_WIDTH'(1);
                    end else begin
                        irow <= irow + CW_ONE;
                    end
                end else begin
                    icol <= icol + CW_ONE;
                end
            end

            // Output side: two passes of 2N beats per buffered row.
            if (out_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= out_word;
                m_axis_tlast  <= out_ch_last;
                m_last_job    <= out_ch_last && (och == ch_q - CH_WIDTH'(1));
                if (oc == n2_m1) begin
                    oc   <= '0;
                    pass <= ~pass;
                    if (pass) begin
                        rbank <= ~rbank;
                        if (orow == n_m1) begin
                            orow <= '0;
                            och  <= och + CH_WIDTH'(1);
                        end else begin
                            orow <= orow + CW_ONE;
                        end
                    end
                end else begin
                    oc <= oc + CW_ONE;
                end
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                m_last_job    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_upsample2x_stream.sv
// Self-checking bench for axis_upsample2x_stream. Expected output beats
// ({tlast, data}) are pushed when an input row is accepted and popped on
// every output handshake.
module tb_axis_upsample2x_stream;
    import axis_upsample2x_stream_pkg::*;

    localparam int W  = 16;
    localparam int CH = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic [2:0]    cfg_log2_dim;
    logic [CH-1:0] cfg_channels;
    logic          cfg_mode;
    logic          busy, done, tlast_err;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
    ups_state_t    state_dbg;

    int vectors     = 0;
    int miscompares = 0;
    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    axis_upsample2x_stream #(.DATA_WIDTH(W), .MAX_LOG2_DIM(6), .CH_WIDTH(CH)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .cfg_log2_dim  (cfg_log2_dim),
        .cfg_channels  (cfg_channels),
        .cfg_mode      (cfg_mode),
        .busy          (busy),
        .done          (done),
        .tlast_err     (tlast_err),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .state_dbg     (state_dbg)
    );

    // Push the 4N expected beats produced from one complete input row.
    task automatic push_row(input int n, input int r, input int mode, input logic [W-1:0] row[64]);
        for (int p = 0; p < 2; p++) begin
            for (int oc = 0; oc < 2 * n; oc++) begin
                logic [W-1:0] d;
                logic         tl;
                d  = (mode == 0 || (p == 0 && oc % 2 == 0)) ? row[oc / 2] : '0;
                tl = (r == n - 1) && (p == 1) && (oc == 2 * n - 1);
                exp_q.push_back({tl, d});
            end
        end
    endtask

    // Runs one job: start pulse, pixel driver, output scoreboard, done check.
    // bad_idx >= 0 moves the input tlast onto that pixel index instead.
    task automatic drive_job(input int k, input int ch, input int mode, input int rdy_pct,
                             input bit seq_data, input int bad_idx, output int beats);
        int n, total_in, total_out, in_idx, cyc;
        logic [W-1:0] row[64];
        logic [W-1:0] cur;
        logic [W:0]   held, exp_v;
        logic         held_v;
        n = 1 << k; total_in = n * n * ch; total_out = 4 * total_in;
        in_idx = 0; cyc = 0; beats = 0; held_v = 1'b0; held = '0;
        exp_q.delete();
        cur = seq_data ? W'(1) : W'($urandom_range(1, 16'hFFFF));

        @(negedge clk);
        cfg_log2_dim = 3'(k); cfg_channels = CH'(ch); cfg_mode = mode[0]; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || tlast_err !== 1'b0 || state_dbg !== ST_RUN) begin
            miscompares++;
            $display("FAIL start: busy=%b tlast_err=%b state=%0d required 1 0 %0d",
                     busy, tlast_err, state_dbg, ST_RUN);
        end

        while (beats < total_out && cyc < 8000) begin
            if (held_v) begin
                vectors++;
                if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold: valid=%b beat=%h required 1 %h",
                             m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, held);
                end
            end
            s_axis_tvalid = (in_idx < total_in);
            s_axis_tdata  = cur;
            s_axis_tlast  = (bad_idx < 0) ? (in_idx % (n * n) == n * n - 1) : (in_idx == bad_idx);
            m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
            #4;
            if (rdy_pct == 100 && beats > 0) begin
                vectors++;
                if (m_axis_tvalid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL gapless: tvalid=%b at beat %0d required 1", m_axis_tvalid, beats);
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                row[in_idx % n] = cur;
                if (in_idx % n == n - 1) push_row(n, (in_idx / n) % n, mode, row);
                in_idx++;
                cur = seq_data ? W'(in_idx + 1) : W'($urandom_range(1, 16'hFFFF));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                vectors++;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if ({m_axis_tlast, m_axis_tdata} !== exp_v) begin
                    miscompares++;
                    $display("FAIL beat %0d: tlast,data=%h required %h", beats,
                             {m_axis_tlast, m_axis_tdata}, exp_v);
                end
                beats++;
                held_v = 1'b0;
            end else begin
                held_v = m_axis_tvalid;
                held   = {m_axis_tlast, m_axis_tdata};
            end
            @(negedge clk);
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        vectors++;
        if (beats != total_out) begin
            miscompares++;
            $display("FAIL job_beats: got %0d required %0d (cycle budget hit)", beats, total_out);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b busy=%b tvalid=%b required 1 0 0",
                     done, busy, m_axis_tvalid);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || state_dbg !== ST_IDLE) begin
            miscompares++;
            $display("FAIL done_end: done=%b state=%0d required 0 %0d", done, state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; cfg_start = 1'b0; cfg_log2_dim = '0; cfg_channels = '0; cfg_mode = 1'b0;
        s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, tlast_err, s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 6'b0 ||
            m_axis_tdata !== '0 || state_dbg !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_state: flags=%b tdata=%h state=%0d required 0",
                     {busy, done, tlast_err, s_axis_tready, m_axis_tvalid, m_axis_tlast},
                     m_axis_tdata, state_dbg);
        end
        reset = 1'b1;
    endtask

    task automatic test_nearest();
        int beats;
        drive_job(2, 1, 0, 100, 1'b1, -1, beats);
        vectors++;
        if (tlast_err !== 1'b0) begin
            miscompares++;
            $display("FAIL nearest_tlast_err: got %b required 0", tlast_err);
        end
    endtask

    task automatic test_zero_insert();
        int beats;
        drive_job(2, 1, 1, 100, 1'b1, -1, beats);
        vectors++;
        if (beats != 64) begin
            miscompares++;
            $display("FAIL zero_beats: got %0d required 64", beats);
        end
    endtask

    task automatic test_random_stall();
        int beats;
        drive_job(3, 2, 0, 50, 1'b0, -1, beats);
        drive_job(3, 2, 1, 50, 1'b0, -1, beats);
    endtask

    task automatic test_tlast_err();
        int beats;
        drive_job(2, 1, 0, 100, 1'b1, 14, beats);
        vectors++;
        if (tlast_err !== 1'b1) begin
            miscompares++;
            $display("FAIL tlast_err_set: got %b required 1", tlast_err);
        end
        // The start check inside the next job verifies the flag is cleared.
        drive_job(1, 1, 0, 100, 1'b1, -1, beats);
    endtask

    task automatic test_mid_reset();
        int sent, beats;
        sent = 0;
        @(negedge clk);
        cfg_log2_dim = 3'd3; cfg_channels = CH'(1); cfg_mode = 1'b0; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < 200 && sent < 20; c++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = W'(sent + 100);
            #4;
            if (s_axis_tready) sent++;
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, tlast_err, s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 6'b0 ||
            m_axis_tdata !== '0 || state_dbg !== ST_IDLE) begin
            miscompares++;
            $display("FAIL mid_reset: flags=%b tdata=%h state=%0d required 0",
                     {busy, done, tlast_err, s_axis_tready, m_axis_tvalid, m_axis_tlast},
                     m_axis_tdata, state_dbg);
        end
        reset = 1'b1;
        drive_job(2, 1, 0, 100, 1'b0, -1, beats);
    endtask

    task automatic test_degenerate(input int k, input int ch);
        @(negedge clk);
        cfg_log2_dim = 3'(k); cfg_channels = CH'(ch); cfg_start = 1'b1;
        s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL degenerate k=%0d c=%0d: done=%b busy=%b s_rdy=%b m_vld=%b required 1 0 0 0",
                     k, ch, done, busy, s_axis_tready, m_axis_tvalid);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL degenerate_end k=%0d c=%0d: done=%b busy=%b s_rdy=%b required 0 0 0",
                     k, ch, done, busy, s_axis_tready);
        end
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nearest();
        test_zero_insert();
        test_random_stall();
        test_tlast_err();
        test_mid_reset();
        test_degenerate(2, 0);
        test_degenerate(7, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
